// File: rtl/muldiv_if.sv
// muldiv_if -- request/response bundle between the EX stage and muldiv_seq.
//   start   : request a new M-extension operation (sampled only when idle)
//   funct3  : operation select (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   op_a    : rs1 operand (multiplicand / dividend)
//   op_b    : rs2 operand (multiplier / divisor)
//   flush   : pipeline flush, aborts any operation in progress
//   busy    : unit is iterating or sign-correcting
//   stall   : combinational hold request to IF/ID/EX
//   done    : one-cycle pulse, result valid while high
//   result  : operation result, held until the next accepted start
// master = requester (pipeline), slave = muldiv_seq.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential radix-2 multiply/divide unit for the RISC-V M extension.
// Fixed latency of XLEN+2 cycles from accepted start to the done pulse, for
// every funct3 including divide-by-zero and signed overflow.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if slave modport (start/funct3/op_a/op_b/flush in,
//           busy/stall/done/result out)
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      fn;
    logic [XLEN-1:0] operand;   // multiplicand for MUL*, divisor for DIV*/REM*
    logic [XLEN-1:0] hi;        // product high half / partial remainder
    logic [XLEN-1:0] lo;        // multiplier -> product low half / dividend -> quotient
    logic            res_neg;   // final result must be negated in FIX
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    // Operand magnitudes and result sign, evaluated on the raw inputs so they
    // can be captured in the same edge that accepts start.
    logic            a_signed, b_signed, a_neg, b_neg, start_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
        a_neg    = a_signed & bus.op_a[XLEN-1];
        b_neg    = b_signed & bus.op_b[XLEN-1];
        a_mag    = a_neg ? -bus.op_a : bus.op_a;
        b_mag    = b_neg ? -bus.op_b : bus.op_b;
        // NOTE: every output of a combinational block needs a value on every
        // path (here via the case default) or synthesis infers a latch.
        case (bus.funct3)
            3'b001:  start_neg = a_neg ^ b_neg;
            3'b010:  start_neg = a_neg;
            // Divide by zero must return all-ones untouched, so no quotient negation.
            3'b100:  start_neg = (a_neg ^ b_neg) & (bus.op_b != '0);
            // Remainder follows the dividend; for a zero divisor this restores op_a.
            3'b110:  start_neg = a_neg;
            default: start_neg = 1'b0;
        endcase
    end

    // One radix-2 iteration for each operation class.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, operand};
        // When div_ge holds the true difference is below the divisor, so the
        // truncated subtraction is exact.
        div_diff  = div_shift[XLEN-1:0] - operand;
    end

    // Sign correction and output selection.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_value;

    always_comb begin
        prod_fix = res_neg ? -{hi, lo} : {hi, lo};
        quot_fix = res_neg ? -lo : lo;
        rem_fix  = res_neg ? -hi : hi;
        if (fn[2])
            fix_value = fn[1] ? rem_fix : quot_fix;
        else if (fn[1:0] == 2'b00)
            fix_value = prod_fix[XLEN-1:0];
        else
            fix_value = prod_fix[2*XLEN-1:XLEN];
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            fn       <= '0;
            operand  <= '0;
            hi       <= '0;
            lo       <= '0;
            res_neg  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fn      <= bus.funct3;
                        res_neg <= start_neg;
                        cnt     <= '0;
                        hi      <= '0;
                        if (bus.funct3[2]) begin
                            operand <= b_mag;
                            lo      <= a_mag;
                        end else begin
                            operand <= a_mag;
                            lo      <= b_mag;
                        end
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // XLEN iterations, then one settling cycle at cnt == XLEN
                    // so the total latency is XLEN+2 edges.
                    if (cnt == CNT_W'(XLEN)) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (fn[2]) begin
                            hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], div_ge};
                        end else begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end
                    end
                end
                FIX: begin
                    result_q <= fix_value;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.stall  = (bus.start & (state == IDLE) & ~bus.flush) | busy_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- self-checking bench for muldiv_seq (XLEN = 32).
// Directed corner cases followed by randomized operations, each compared
// against an arithmetic reference model of the M-extension semantics.
module tb_muldiv_seq;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the RISC-V definitions.
    function automatic logic [XLEN-1:0] model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = 64'(sa / sb);
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a falling edge. Issues one operation and follows it for a
    // fixed window, checking latency, single done pulse, value and hold.
    task automatic run_op(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input string tag, input bit chk_stall);
        logic [XLEN-1:0] exp;
        logic [XLEN-1:0] got;
        int              lat;
        int              pulses;
        exp        = model(f, a, b);
        got        = 'x;
        lat        = -1;
        pulses     = 0;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        #1;
        if (chk_stall) check({tag, "_stall_req"}, 32'(bus.stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < XLEN + 12; k++) begin
            if (bus.done) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got = bus.result;
                end
            end
            if (chk_stall) check($sformatf("%s_stall_c%0d", tag, k), 32'(bus.stall),
                                 32'(k <= XLEN + 1));
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(lat), 32'(XLEN + 2));
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_result"}, got, exp);
        check({tag, "_held"}, bus.result, exp);
    endtask

    initial begin
        logic [XLEN-1:0] prev;
        logic [XLEN-1:0] exp;
        logic [XLEN-1:0] got;
        int              pulses;

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus.busy),  32'd0);
        check("rst_done",   32'(bus.done),  32'd0);
        check("rst_stall",  32'(bus.stall), 32'd0);
        check("rst_result", bus.result,     32'd0);

        // Start on the first edge after reset release, with full stall trace.
        rst_n = 1'b1;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, "mul_7x-3", 1'b1);

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff", 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff", 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff", 1'b0);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "div_-7_2", 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, "rem_-7_2", 1'b0);
        run_op(3'b101, 32'd7, 32'd2, "divu_7_2", 1'b0);
        run_op(3'b111, 32'd7, 32'd2, "remu_7_2", 1'b0);
        run_op(3'b100, 32'h1234_5678, 32'd0, "div_by0", 1'b0);
        run_op(3'b101, 32'h1234_5678, 32'd0, "divu_by0", 1'b0);
        run_op(3'b110, 32'h1234_5678, 32'd0, "rem_by0", 1'b0);
        run_op(3'b111, 32'h1234_5678, 32'd0, "remu_by0", 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd0, "rem_neg_by0", 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        run_op(3'b101, 32'd7, 32'd2, "divu_prev", 1'b0);
        prev = 32'd3;

        // Flush at cycle 10 of a DIV.
        bus.funct3 = 3'b100;
        bus.op_a   = 32'hFFFF_FFF9;
        bus.op_b   = 32'd2;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_after",  32'(bus.busy),  32'd0);
        check("flush_stall_after", 32'(bus.stall), 32'd0);
        check("flush_result_kept", bus.result,     prev);
        pulses = 0;
        repeat (XLEN + 8) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(pulses), 32'd0);
        check("flush_result_still", bus.result, prev);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, "after_flush", 1'b0);

        // start and flush together in IDLE must not launch anything.
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd5;
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        #1;
        check("startflush_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("startflush_busy", 32'(bus.busy), 32'd0);
        pulses = 0;
        repeat (XLEN + 8) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        check("startflush_no_done", 32'(pulses), 32'd0);

        // start pulsed during CALC is ignored.
        exp        = model(3'b000, 32'd12345, 32'd678);
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd12345;
        bus.op_b   = 32'd678;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.funct3 = 3'b101;
        bus.op_a   = 32'd99;
        bus.op_b   = 32'd3;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        pulses    = 0;
        got       = 'x;
        repeat (2 * XLEN + 10) begin
            if (bus.done) begin
                pulses++;
                got = bus.result;
            end
            @(negedge clk);
        end
        check("calc_start_pulses", 32'(pulses), 32'd1);
        check("calc_start_result", got, exp);

        // Reset at cycle 20 of an operation.
        bus.funct3 = 3'b101;
        bus.op_a   = 32'd1000;
        bus.op_b   = 32'd7;
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(bus.busy), 32'd0);
        check("midrst_done",   32'(bus.done), 32'd0);
        check("midrst_result", bus.result,    32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (XLEN + 8) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        check("midrst_no_done", 32'(pulses), 32'd0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), $sformatf("rand%0d", i), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
